// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle load/store stage between execute and write-back.
// Latches one request on start, drives a req/ack data port, returns a
// one-cycle write-back pulse and raises busy while a transaction is open.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   start, memRead, memWrite,    request handshake and decode
//   memToReg, funct3
//   ALUresult, regReadData2, rd  address / pass-through, store data, dest reg
//   memAddr, memWriteData,       data memory request (word-aligned address,
//   memByteEn, memReq, memWe     lane-shifted data, byte enables)
//   memAck, memReadData          data memory response
//   regWriteData, regWriteRd,    write-back result and strobe
//   regWriteValid
//   busy, misaligned             stall indication, misalignment strobe
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   : misaligned H/W/D accesses skip memory and pulse misaligned
//   undefined : low address bits are cleared (access aligned down),
//               misaligned stays 0
module mem_access_unit #(
    parameter int WORD_BITWIDTH    = 32,
    parameter int REG_NUM_BITWIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        memRead,
    input  logic                        memWrite,
    input  logic                        memToReg,
    input  logic [2:0]                  funct3,
    input  logic [WORD_BITWIDTH-1:0]    ALUresult,
    input  logic [WORD_BITWIDTH-1:0]    regReadData2,
    input  logic [REG_NUM_BITWIDTH-1:0] rd,
    output logic [WORD_BITWIDTH-1:0]    memAddr,
    output logic [WORD_BITWIDTH-1:0]    memWriteData,
    output logic [WORD_BITWIDTH/8-1:0]  memByteEn,
    output logic                        memReq,
    output logic                        memWe,
    input  logic                        memAck,
    input  logic [WORD_BITWIDTH-1:0]    memReadData,
    output logic [WORD_BITWIDTH-1:0]    regWriteData,
    output logic [REG_NUM_BITWIDTH-1:0] regWriteRd,
    output logic                        regWriteValid,
    output logic                        busy,
    output logic                        misaligned
);

    localparam int NB = WORD_BITWIDTH / 8;
    localparam int OB = $clog2(NB);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Doubleword has no meaning on a 32-bit datapath; it behaves as word.
    function automatic logic [1:0] effSize(input logic [1:0] s);
        if (WORD_BITWIDTH == 32 && s == 2'b11)
            return 2'b10;
        return s;
    endfunction

    // One enable bit per byte of the access, starting at lane 0.
    function automatic logic [NB-1:0] sizeMask(input logic [1:0] s);
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++)
            m[i] = (i < (1 << s));
        return m;
    endfunction

    // Offset bits that must be zero for a naturally aligned access.
    function automatic logic [OB-1:0] offMask(input logic [1:0] s);
        logic [OB-1:0] m;
        for (int b = 0; b < OB; b++)
            m[b] = (b < int'(s));
        return m;
    endfunction

    // Request-side decode, evaluated on the incoming operands.
    logic [1:0]    inSize;
    logic [OB-1:0] rawOff;
    logic [OB-1:0] inMask;
    logic [OB-1:0] inOff;

    always_comb begin
        inSize = effSize(funct3[1:0]);
        rawOff = ALUresult[OB-1:0];
        inMask = offMask(inSize);
        // Aligned-down lane offset; equals rawOff whenever the access is aligned.
        inOff  = rawOff & ~inMask;
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic trapHit;
    assign trapHit = |(rawOff & inMask);
`endif

    // Latched request fields.
    logic [OB-1:0]               offQ;
    logic [1:0]                  sizeQ;
    logic                        unsignedQ;
    logic                        toRegQ;
    logic                        storeQ;
    logic [WORD_BITWIDTH-1:0]    aluQ;
    logic [REG_NUM_BITWIDTH-1:0] rdQ;

    // Load path: bring the addressed lane down to bit 0, then extend.
    logic [WORD_BITWIDTH-1:0] shifted;
    logic [WORD_BITWIDTH-1:0] loadResult;
    logic                     signBit;
    int                       loadBits;

    always_comb begin
        shifted  = memReadData >> {offQ, 3'b000};
        loadBits = 8 << sizeQ;
        unique case (sizeQ)
            2'b00:   signBit = shifted[7];
            2'b01:   signBit = shifted[15];
            2'b10:   signBit = shifted[31];
            default: signBit = shifted[WORD_BITWIDTH-1];
        endcase
        loadResult = shifted;
        for (int i = 0; i < WORD_BITWIDTH; i++) begin
            if (i >= loadBits)
                loadResult[i] = ~unsignedQ & signBit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            memAddr       <= '0;
            memWriteData  <= '0;
            memByteEn     <= '0;
            memReq        <= 1'b0;
            memWe         <= 1'b0;
            regWriteData  <= '0;
            regWriteRd    <= '0;
            regWriteValid <= 1'b0;
            busy          <= 1'b0;
            misaligned    <= 1'b0;
            offQ          <= '0;
            sizeQ         <= '0;
            unsignedQ     <= 1'b0;
            toRegQ        <= 1'b0;
            storeQ        <= 1'b0;
            aluQ          <= '0;
            rdQ           <= '0;
        end else begin
            regWriteValid <= 1'b0;
            misaligned    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        offQ      <= inOff;
                        sizeQ     <= inSize;
                        unsignedQ <= funct3[2];
                        toRegQ    <= memToReg;
                        storeQ    <= memWrite;
                        aluQ      <= ALUresult;
                        rdQ       <= rd;
                        busy      <= 1'b1;
                        if (!(memRead || memWrite)) begin
                            state         <= DONE;
                            regWriteValid <= 1'b1;
                            regWriteData  <= ALUresult;
                            regWriteRd    <= rd;
                        end
`ifdef MEM_MISALIGN_TRAP_EN
                        else if (trapHit) begin
                            state      <= DONE;
                            misaligned <= 1'b1;
                        end
`endif
                        else begin
                            state        <= REQ;
                            memReq       <= 1'b1;
                            memWe        <= memWrite;
                            memAddr      <= {ALUresult[WORD_BITWIDTH-1:OB],
                                             {OB{1'b0}}};
                            memByteEn    <= sizeMask(inSize) << inOff;
                            memWriteData <= regReadData2 << {inOff, 3'b000};
                        end
                    end
                end
                REQ: begin
                    if (memAck) begin
                        state  <= DONE;
                        memReq <= 1'b0;
                        memWe  <= 1'b0;
                        // Stores (including read+write requests) never write back.
                        if (!storeQ) begin
                            regWriteValid <= 1'b1;
                            regWriteData  <= toRegQ ? loadResult : aluQ;
                            regWriteRd    <= rdQ;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    memReq <= 1'b0;
                    memWe  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit (W=32).
// Expected values come from an arithmetic model of the access rules.
module tb_mem_access_unit;

    localparam int W = 32;
    localparam int R = 5;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         memRead;
    logic         memWrite;
    logic         memToReg;
    logic [2:0]   funct3;
    logic [W-1:0] ALUresult;
    logic [W-1:0] regReadData2;
    logic [R-1:0] rd;
    logic [W-1:0] memAddr;
    logic [W-1:0] memWriteData;
    logic [3:0]   memByteEn;
    logic         memReq;
    logic         memWe;
    logic         memAck;
    logic [W-1:0] memReadData;
    logic [W-1:0] regWriteData;
    logic [R-1:0] regWriteRd;
    logic         regWriteValid;
    logic         busy;
    logic         misaligned;

    mem_access_unit #(.WORD_BITWIDTH(W), .REG_NUM_BITWIDTH(R)) dut (
        .clk(clk), .rst(rst), .start(start),
        .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg),
        .funct3(funct3), .ALUresult(ALUresult),
        .regReadData2(regReadData2), .rd(rd),
        .memAddr(memAddr), .memWriteData(memWriteData),
        .memByteEn(memByteEn), .memReq(memReq), .memWe(memWe),
        .memAck(memAck), .memReadData(memReadData),
        .regWriteData(regWriteData), .regWriteRd(regWriteRd),
        .regWriteValid(regWriteValid), .busy(busy),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Access rules in plain arithmetic.
    function automatic void model(input logic [2:0] f3,
                                  input logic [31:0] addr,
                                  input logic [31:0] wd,
                                  input logic [31:0] rdat,
                                  output logic [31:0] mAddr,
                                  output logic [3:0] mBE,
                                  output logic [31:0] mWD,
                                  output logic [31:0] mLd,
                                  output bit mis);
        int sz, nb, raw, off;
        logic [63:0] v, m;
        sz = int'(f3[1:0]);
        if (sz == 3) sz = 2;
        nb    = 1 << sz;
        raw   = int'(addr[1:0]);
        mis   = (raw % nb) != 0;
        off   = raw - (raw % nb);
        mAddr = addr - 32'(raw);
        mBE   = 4'(((1 << nb) - 1) << off);
        mWD   = wd << (8 * off);
        v     = 64'(rdat) >> (8 * off);
        m     = (64'd1 << (8 * nb)) - 64'd1;
        v     = v & m;
        if (!f3[2] && v[8 * nb - 1]) v = v | ~m;
        mLd   = v[31:0];
    endfunction

    bit          cmpEn = 1'b0;
    bit          expReq, expBusy, expValid, expMis;
    logic [31:0] eAddr, eWD, eWb;
    logic [3:0]  eBE;
    logic        eWe;
    logic [4:0]  eRd;
    int          seenReq, seenMis;
    logic [31:0] seenAddr, seenWD;
    logic [3:0]  seenBE;
    logic        seenWe;

    always @(negedge clk) begin
        if (cmpEn) begin
            chk("memReq", memReq, expReq);
            chk("busy", busy, expBusy);
            chk("regWriteValid", regWriteValid, expValid);
            chk("misaligned", misaligned, expMis);
            if (memReq) begin
                seenReq++;
                seenAddr = memAddr;
                seenBE   = memByteEn;
                seenWD   = memWriteData;
                seenWe   = memWe;
            end
            if (misaligned) seenMis++;
            if (expReq) begin
                chk("memAddr", memAddr, eAddr);
                chk("memByteEn", memByteEn, eBE);
                chk("memWe", memWe, eWe);
                if (eWe) chk("memWriteData", memWriteData, eWD);
            end
            if (expValid) begin
                chk("regWriteData", regWriteData, eWb);
                chk("regWriteRd", regWriteRd, eRd);
            end
        end
    end

    task automatic setIdle();
        expReq = 0; expBusy = 0; expValid = 0; expMis = 0;
    endtask

    task automatic idle(input int n);
        setIdle();
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Runs one transaction from a posedge+1 and returns at posedge+1 of
    // the idle cycle after DONE. vCyc is the cycle of regWriteValid (or -1).
    task automatic runOp(input logic rF, input logic wF, input logic tR,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdat,
                         input logic [4:0] rdI, input int ackAt,
                         input bit poke, output int vCyc);
        logic [31:0] ld;
        bit mis, isMem, trapHit;
        int cyc;
        model(f3, addr, wd, rdat, eAddr, eBE, eWD, ld, mis);
        isMem   = rF | wF;
        trapHit = TRAP && isMem && mis;
        eWe = wF; eWb = tR ? ld : addr; eRd = rdI;
        seenReq = 0; seenMis = 0; vCyc = -1;
        start = 1; memRead = rF; memWrite = wF; memToReg = tR;
        funct3 = f3; ALUresult = addr; regReadData2 = wd; rd = rdI;
        setIdle();
        @(posedge clk); #1;
        start = 0; memRead = 0; memWrite = 0;
        ALUresult = 32'hDEAD_0000; regReadData2 = 32'h0; rd = 5'd0;
        cyc = 1;
        if (isMem && !trapHit) begin
            for (cyc = 1; cyc <= ackAt; cyc++) begin
                expReq = 1; expBusy = 1;
                if (poke && cyc == 1) begin
                    start = 1; ALUresult = 32'h5555_5555; rd = 5'd31;
                end
                memAck      = (cyc == ackAt);
                memReadData = (cyc == ackAt) ? rdat : ~rdat;
                @(posedge clk); #1;
                start = 0; memAck = 0;
            end
        end
        expReq = 0; expBusy = 1;
        expValid = !trapHit && !wF;
        expMis = trapHit;
        if (expValid) vCyc = cyc;
        memAck = 1;
        @(posedge clk); #1;
        memAck = 0;
        setIdle();
    endtask

    int v;

    initial begin
        rst = 1; start = 0; memRead = 0; memWrite = 0; memToReg = 0;
        funct3 = 0; ALUresult = 0; regReadData2 = 0; rd = 0;
        memAck = 0; memReadData = 0;
        setIdle();
        #2;
        chk("rst memReq", memReq, 0);
        chk("rst memWe", memWe, 0);
        chk("rst busy", busy, 0);
        chk("rst valid", regWriteValid, 0);
        chk("rst misaligned", misaligned, 0);
        chk("rst memAddr", memAddr, 0);
        chk("rst memByteEn", memByteEn, 0);
        chk("rst memWriteData", memWriteData, 0);
        chk("rst regWriteData", regWriteData, 0);
        chk("rst regWriteRd", regWriteRd, 0);
        repeat (2) @(posedge clk);
        #1; rst = 0; cmpEn = 1;
        idle(1);

        runOp(1, 0, 1, 3'b000, 32'h1003, 0, 32'h80FF_FF12, 5'd5, 3, 0, v);
        chk("LB data", regWriteData, 32'hFFFF_FF80);
        chk("LB cycle", v, 4);
        idle(2);
        chk("LB hold data", regWriteData, 32'hFFFF_FF80);
        chk("LB hold rd", regWriteRd, 5'd5);

        runOp(1, 0, 1, 3'b101, 32'h2002, 0, 32'hBEEF_0000, 5'd6, 1, 0, v);
        chk("LHU data", regWriteData, 32'h0000_BEEF);
        chk("LHU cycle", v, 2);

        runOp(0, 1, 0, 3'b000, 32'h0001, 32'hAB, 0, 5'd7, 2, 0, v);
        chk("SB byteEn", seenBE, 4'b0010);
        chk("SB wdata", seenWD, 32'h0000_AB00);
        chk("SB we", seenWe, 1);
        chk("SB no valid", v, -1);

        runOp(0, 0, 0, 3'b010, 32'h1234, 0, 0, 5'd8, 1, 0, v);
        chk("ALU data", regWriteData, 32'h1234);
        chk("ALU cycle", v, 1);
        chk("ALU no req", seenReq, 0);

        runOp(1, 0, 1, 3'b010, 32'h0002, 0, 32'h1122_3344, 5'd9, 1, 0, v);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("LW mis no req", seenReq, 0);
        chk("LW mis pulse", seenMis, 1);
        chk("LW mis no valid", v, -1);
`else
        chk("LW align addr", seenAddr, 32'h0);
        chk("LW align byteEn", seenBE, 4'hF);
        chk("LW align data", regWriteData, 32'h1122_3344);
`endif

        runOp(1, 0, 1, 3'b001, 32'h0002, 0, 32'h8001_7777, 5'd10, 2, 0, v);
        chk("LH data", regWriteData, 32'hFFFF_8001);
        runOp(1, 0, 1, 3'b100, 32'h0001, 0, 32'h0000_F000, 5'd11, 1, 0, v);
        chk("LBU data", regWriteData, 32'h0000_00F0);
        runOp(0, 1, 0, 3'b010, 32'h0010, 32'hDEAD_BEEF, 0, 5'd12, 1, 0, v);
        chk("SW byteEn", seenBE, 4'hF);
        runOp(0, 1, 0, 3'b001, 32'h0002, 32'h1234_5678, 0, 5'd13, 2, 0, v);
        chk("SH byteEn", seenBE, 4'b1100);
        chk("SH wdata", seenWD, 32'h5678_0000);
        runOp(1, 0, 0, 3'b010, 32'h0008, 0, 32'h7777_7777, 5'd14, 1, 0, v);
        chk("LW alu data", regWriteData, 32'h0000_0008);
        runOp(1, 1, 1, 3'b010, 32'h0004, 32'hA5A5_A5A5, 0, 5'd15, 1, 0, v);
        chk("RW is store", seenWe, 1);
        chk("RW no valid", v, -1);
        runOp(1, 0, 1, 3'b011, 32'h000C, 0, 32'hCAFE_BABE, 5'd16, 2, 0, v);
        chk("LD32 byteEn", seenBE, 4'hF);
        chk("LD32 data", regWriteData, 32'hCAFE_BABE);
        runOp(1, 0, 1, 3'b010, 32'h0100, 0, 32'h0BAD_F00D, 5'd17, 3, 1, v);
        chk("busy start rd", regWriteRd, 5'd17);
        chk("busy start data", regWriteData, 32'h0BAD_F00D);

        // Reset while the request is outstanding.
        model(3'b010, 32'h40, 0, 0, eAddr, eBE, eWD, eWb, expMis);
        eWe = 0; eRd = 5'd18;
        start = 1; memRead = 1; memToReg = 1; funct3 = 3'b010;
        ALUresult = 32'h40; rd = 5'd18;
        setIdle();
        @(posedge clk); #1;
        start = 0; memRead = 0;
        expReq = 1; expBusy = 1;
        @(posedge clk); #1;
        cmpEn = 0;
        rst = 1;
        #1;
        chk("midrst memReq", memReq, 0);
        chk("midrst busy", busy, 0);
        chk("midrst valid", regWriteValid, 0);
        @(posedge clk); #1;
        rst = 0;
        setIdle();
        memAck = 1;
        cmpEn = 1;
        idle(2);
        memAck = 0;
        runOp(1, 0, 1, 3'b000, 32'h0042, 0, 32'h0077_0000, 5'd19, 2, 0, v);
        chk("post rst data", regWriteData, 32'h0000_0077);
        chk("post rst cycle", v, 3);

        idle(2);
        cmpEn = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
